obj_pos_ctrl: RTL and testbench
===============================

# obj_pos_ctrl

Horizontal position register and motion engine for one TIA movable object (player, missile or ball). It produces the 8-bit object position consumed by the pixel-on decode logic and updates it from reset strobes (RESPx/RESMx/RESBL), the HMxx motion register, HMOVE and HMCLR, and missile-to-player lock (RESMPx). The position is kept in the visible range 0..159. The object's first lit pixel is `pixel_num = obj_pos + 1`.

## Interface
- `RES_OFFSET`, default 4: pixels added to `pixel_num` when a reset strobe lands in the visible region.
- `HBLANK_POS`, default 3: position loaded when a reset strobe lands during HBLANK.
- `LOCK_OFFSET`, default 5: offset from `ref_pos` while missile lock is active.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `pix_ce` in 1: color-clock enable; motion advances only on cycles where it is high.
- `pixel_num` in 8: current visible pixel, 0..159.
- `hblank` in 1: horizontal blank active.
- `res_stb` in 1: one-cycle position reset strobe.
- `hm_wr` in 1: one-cycle write of `hm_data` into the motion register.
- `hm_data` in 4: signed motion, -8..+7; positive moves left.
- `hmclr_stb` in 1: one-cycle clear of the motion register.
- `hmove_stb` in 1: one-cycle HMOVE strobe.
- `lock` in 1: missile lock to `ref_pos`.
- `ref_pos` in 8: position of the parent player, 0..159.
- `obj_pos` out 8: object position, 0..159.
- `hm_reg` out 4: current motion register.
- `busy` out 1: motion in progress.

## Operation
- **State machine:**
  - IDLE: `busy=0`.
  - MOVE: step counter `cnt`, 4 bits, holds the magnitude; `dir` holds the sign.
- **Position wrap:** all position arithmetic is done in 9 bits, then reduced modulo 160.
  - Increment from 159 wraps to 0.
  - Decrement from 0 wraps to 159.
- **Reset strobe (`res_stb`):**
  - If `hblank=0`, `obj_pos <= (pixel_num + RES_OFFSET) mod 160`.
  - If `hblank=1`, `obj_pos <= HBLANK_POS`.
  - Any move in progress is aborted and the state returns to IDLE.
- **Motion register (`hm_wr`, `hmclr_stb`):**
  - `hm_wr` loads `hm_reg`.
  - `hmclr_stb` clears `hm_reg` to 0.
  - If both are asserted in the same cycle, `hm_wr` wins.
- **HMOVE (`hmove_stb`):**
  - If `hm_reg` is 0, the block stays in IDLE.
  - Otherwise it enters MOVE with `cnt = |hm_reg|` and `dir = hm_reg[3]`. For `hm_reg = 1000` (-8), `cnt = 8`.
  - On each `pix_ce` cycle in MOVE, `obj_pos` steps by one pixel:
    - `hm_reg[3] = 0` (positive): decrement (move left).
    - `hm_reg[3] = 1` (negative): increment.
  - `cnt` decrements on each step; the block returns to IDLE after the step that makes `cnt` reach 0.
  - `hmove_stb` while in MOVE restarts the move from the current `obj_pos` using the current `hm_reg`.
  - `hm_wr` while in MOVE changes only `hm_reg`; the active `cnt`/`dir` are unaffected.
- **Lock (`lock=1`):**
  - Every cycle, `obj_pos <= (ref_pos + LOCK_OFFSET) mod 160`.
  - `res_stb` and `hmove_stb` are ignored; the state is forced to IDLE and `busy=0`.
  - When `lock` falls, the position holds its last locked value.
- **Priority, highest first:** `lock` > `res_stb` > `hmove_stb` > MOVE stepping.
- Out-of-range inputs (`pixel_num` or `ref_pos` ≥ 160) are reduced modulo 160 before use.

## Timing
- Reset (`rst_n` low, asynchronous): `obj_pos = 0`, `hm_reg = 0`, `busy = 0`, `cnt = 0`, state IDLE. Release is synchronous to `clk`.
- All outputs are registered; there is no combinational path from input to output.
- `res_stb`, `hm_wr`, `hmclr_stb` and `lock` take effect on the same rising edge that samples them. They do not depend on `pix_ce`.
- `hmove_stb`:
  - `busy` rises on the sampling edge.
  - The first step occurs on the next edge with `pix_ce=1`.
  - A move of N steps completes after N `pix_ce` cycles, and `busy` falls on the edge of the last step.
- `res_stb` in the same cycle as the final MOVE step: the reset value wins and `busy` falls.
- `hmove_stb` and `res_stb` together: the reset is applied and no move starts.
- With `pix_ce` held low, MOVE holds with `busy=1` indefinitely.

## Test plan
- Reset → `obj_pos=0`, `hm_reg=0`, `busy=0`; apply `res_stb` with `pixel_num=100`, `hblank=0` → `obj_pos=104` on the next edge.
- `res_stb` with `pixel_num=158` → `obj_pos=2` (wrap); `res_stb` with `hblank=1` → `obj_pos=3`.
- `obj_pos=10`, `hm_wr` with 0111, then `hmove_stb`, with `pix_ce` every 3rd cycle → `obj_pos` steps 9..3, `busy` high for exactly 7 `pix_ce` pulses.
- `obj_pos=155`, `hm_wr` with 1000 (-8), then `hmove_stb` → `obj_pos` steps 156..159, then 0..3; final value 3.
- `hm_wr` and `hmclr_stb` in the same cycle with 0101 → `hm_reg=5`; `hmclr_stb` alone → 0; `hmove_stb` with `hm_reg=0` → `busy` stays 0.
- `lock=1` with `ref_pos=157` → `obj_pos=2`; while locked, `res_stb` and `hmove_stb` have no effect; `res_stb` mid-move (unlocked) → move aborted and `busy=0` on the same edge.

Source files
------------

// File: rtl/obj_pos_ctrl.sv
// Horizontal position register and HMOVE motion engine for one movable object.
// Handles reset strobes, motion register load/clear, stepped HMOVE and missile lock.
module obj_pos_ctrl #(
  parameter int RES_OFFSET  = 4,
  parameter int HBLANK_POS  = 3,
  parameter int LOCK_OFFSET = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_ce,
  input  logic [7:0] pixel_num,
  input  logic       hblank,
  input  logic       res_stb,
  input  logic       hm_wr,
  input  logic [3:0] hm_data,
  input  logic       hmclr_stb,
  input  logic       hmove_stb,
  input  logic       lock,
  input  logic [7:0] ref_pos,
  output logic [7:0] obj_pos,
  output logic [3:0] hm_reg,
  output logic       busy
);

  typedef enum logic {S_IDLE, S_MOVE} state_t;

  state_t     state_q, state_d;
  logic [7:0] pos_q, pos_d;
  logic [3:0] hm_q, hm_d;
  logic [3:0] cnt_q, cnt_d;
  logic       dir_q, dir_d;

  // Reduce a value below 320 into 0..159.
  function automatic logic [7:0] wrap160(input logic [8:0] v);
    if (v >= 9'd160) return 8'(v - 9'd160);
    else             return v[7:0];
  endfunction

  function automatic logic [7:0] add_mod(input logic [7:0] base, input logic [8:0] ofs);
    return wrap160({1'b0, wrap160({1'b0, base})} + ofs);
  endfunction

  // dir=0 (positive motion) moves left, i.e. decrements.
  function automatic logic [7:0] step_pos(input logic [7:0] p, input logic d);
    if (d) return (p == 8'd159) ? 8'd0 : p + 8'd1;
    else   return (p == 8'd0) ? 8'd159 : p - 8'd1;
  endfunction

  function automatic logic [3:0] mag(input logic [3:0] m);
    return m[3] ? (~m + 4'd1) : m;
  endfunction

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    hm_d    = hm_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;

    if (hm_wr)          hm_d = hm_data;
    else if (hmclr_stb) hm_d = 4'd0;

    if (lock) begin
      pos_d   = add_mod(ref_pos, 9'(LOCK_OFFSET));
      state_d = S_IDLE;
      cnt_d   = 4'd0;
    end else if (res_stb) begin
      pos_d   = hblank ? 8'(HBLANK_POS) : add_mod(pixel_num, 9'(RES_OFFSET));
      state_d = S_IDLE;
      cnt_d   = 4'd0;
    end else if (hmove_stb) begin
      // Restart uses the registered motion value, not a same-cycle write.
      if (hm_q != 4'd0) begin
        state_d = S_MOVE;
        cnt_d   = mag(hm_q);
        dir_d   = hm_q[3];
      end else begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    end else if (state_q == S_MOVE && pix_ce) begin
      pos_d = step_pos(pos_q, dir_q);
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pos_q   <= 8'd0;
      hm_q    <= 4'd0;
      cnt_q   <= 4'd0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      hm_q    <= hm_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  assign obj_pos = pos_q;
  assign hm_reg  = hm_q;
  assign busy    = (state_q == S_MOVE);

endmodule

// File: tb/tb_obj_pos_ctrl.sv
// Scoreboard bench for obj_pos_ctrl: stimulus pushes expected state after each
// edge, a negedge monitor pops and compares against the outputs.
module tb_obj_pos_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_ce;
  logic [7:0] pixel_num;
  logic       hblank;
  logic       res_stb;
  logic       hm_wr;
  logic [3:0] hm_data;
  logic       hmclr_stb;
  logic       hmove_stb;
  logic       lock;
  logic [7:0] ref_pos;
  logic [7:0] obj_pos;
  logic [3:0] hm_reg;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] pos;
    logic [3:0] hm;
    logic       bsy;
  } exp_t;

  exp_t sb_q[$];

  obj_pos_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .pixel_num(pixel_num),
    .hblank(hblank), .res_stb(res_stb), .hm_wr(hm_wr), .hm_data(hm_data),
    .hmclr_stb(hmclr_stb), .hmove_stb(hmove_stb), .lock(lock),
    .ref_pos(ref_pos), .obj_pos(obj_pos), .hm_reg(hm_reg), .busy(busy)
  );

  always #5 clk = ~clk;

  // Monitor: drains every expectation queued since the last edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if (obj_pos !== e.pos || hm_reg !== e.hm || busy !== e.bsy) begin
        errors++;
        $display("FAIL %s: got pos=%0d hm=%b busy=%b, want pos=%0d hm=%b busy=%b",
                 e.name, obj_pos, hm_reg, busy, e.pos, e.hm, e.bsy);
      end
    end
  end

  task automatic expect_st(input string n, input int p, input logic [3:0] h, input logic b);
    exp_t e;
    e.name = n; e.pos = 8'(p); e.hm = h; e.bsy = b;
    sb_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_res(input int pix, input logic hb);
    pixel_num = 8'(pix); hblank = hb; res_stb = 1'b1;
    cyc();
    res_stb = 1'b0; hblank = 1'b0;
  endtask

  task automatic do_hm(input logic [3:0] v);
    hm_data = v; hm_wr = 1'b1;
    cyc();
    hm_wr = 1'b0;
  endtask

  task automatic do_hmove();
    hmove_stb = 1'b1;
    cyc();
    hmove_stb = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int want;
    rst_n = 1'b0; pix_ce = 1'b1; pixel_num = 8'd0; hblank = 1'b0;
    res_stb = 1'b0; hm_wr = 1'b0; hm_data = 4'd0; hmclr_stb = 1'b0;
    hmove_stb = 1'b0; lock = 1'b0; ref_pos = 8'd0;
    #2;
    expect_st("reset", 0, 4'd0, 1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();

    do_res(100, 1'b0); expect_st("res_100", 104, 4'd0, 1'b0);
    do_res(158, 1'b0); expect_st("res_wrap", 2, 4'd0, 1'b0);
    do_res(50, 1'b1);  expect_st("res_hblank", 3, 4'd0, 1'b0);
    do_res(250, 1'b0); expect_st("res_oor", 94, 4'd0, 1'b0);

    // +7 move from 10 with pix_ce every third cycle
    do_res(6, 1'b0); expect_st("pos10", 10, 4'd0, 1'b0);
    do_hm(4'b0111);  expect_st("hm7", 10, 4'd7, 1'b0);
    pix_ce = 1'b0;
    do_hmove();      expect_st("hmove7_start", 10, 4'd7, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      cyc(); expect_st("hold_a", 11 - k, 4'd7, 1'b1);
      cyc(); expect_st("hold_b", 11 - k, 4'd7, 1'b1);
      pix_ce = 1'b1;
      cyc(); expect_st("step_left", 10 - k, 4'd7, (k < 7));
      pix_ce = 1'b0;
    end
    pix_ce = 1'b1;
    cyc(); expect_st("after_move7", 3, 4'd7, 1'b0);

    // -8 move from 155 wraps through 159 -> 0
    do_res(151, 1'b0); expect_st("pos155", 155, 4'd7, 1'b0);
    do_hm(4'b1000);    expect_st("hm_m8", 155, 4'b1000, 1'b0);
    do_hmove();        expect_st("hmove_m8_start", 155, 4'b1000, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      want = (155 + k) % 160;
      cyc(); expect_st("step_right", want, 4'b1000, (k < 8));
    end

    // Motion register load/clear priority
    hm_data = 4'b0101; hm_wr = 1'b1; hmclr_stb = 1'b1;
    cyc();
    hm_wr = 1'b0; hmclr_stb = 1'b0;
    expect_st("wr_beats_clr", 3, 4'd5, 1'b0);
    hmclr_stb = 1'b1; cyc(); hmclr_stb = 1'b0;
    expect_st("hmclr", 3, 4'd0, 1'b0);
    do_hmove(); expect_st("hmove_zero", 3, 4'd0, 1'b0);
    cyc();      expect_st("hmove_zero_idle", 3, 4'd0, 1'b0);

    // Lock overrides reset and hmove
    lock = 1'b1; ref_pos = 8'd157;
    cyc(); expect_st("lock157", 2, 4'd0, 1'b0);
    do_hm(4'b0101); expect_st("lock_hmwr", 2, 4'd5, 1'b0);
    do_res(100, 1'b0); expect_st("lock_res", 2, 4'd5, 1'b0);
    do_hmove(); expect_st("lock_hmove", 2, 4'd5, 1'b0);
    ref_pos = 8'd200;
    cyc(); expect_st("lock_oor", 45, 4'd5, 1'b0);
    lock = 1'b0;
    cyc(); expect_st("unlock_hold", 45, 4'd5, 1'b0);

    // Reset strobe aborts a move
    do_hmove(); expect_st("move5_start", 45, 4'd5, 1'b1);
    cyc();      expect_st("move5_step", 44, 4'd5, 1'b1);
    do_res(0, 1'b1); expect_st("res_abort", 3, 4'd5, 1'b0);

    // Reset strobe coinciding with the final step
    do_hm(4'b0001); expect_st("hm1", 3, 4'd1, 1'b0);
    do_hmove();     expect_st("move1_start", 3, 4'd1, 1'b1);
    do_res(20, 1'b0); expect_st("res_on_last", 24, 4'd1, 1'b0);

    // hmove and res_stb together: reset wins, no move
    pixel_num = 8'd30; res_stb = 1'b1; hmove_stb = 1'b1;
    cyc();
    res_stb = 1'b0; hmove_stb = 1'b0;
    expect_st("res_and_hmove", 34, 4'd1, 1'b0);
    cyc(); expect_st("res_and_hmove_idle", 34, 4'd1, 1'b0);

    // hm_wr mid-move leaves the active count alone
    do_hm(4'b0010); expect_st("hm2", 34, 4'd2, 1'b0);
    do_hmove();     expect_st("move2_start", 34, 4'd2, 1'b1);
    do_hm(4'b0111); expect_st("move2_wr", 33, 4'd7, 1'b1);
    cyc();          expect_st("move2_done", 32, 4'd7, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
